// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared FSM state and op encodings for the sequential
// multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/multdiv_iter_step.sv
// multdiv_iter_step: one combinational radix-2 iteration on operand magnitudes,
// shift-add for multiply or non-restoring for divide.
module multdiv_iter_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_part,
  input  logic [WIDTH-1:0] i_opnd,
  input  logic             i_op,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_part
);

  logic [WIDTH:0] w_opnd_ext;
  logic [WIDTH:0] w_mul_sum;
  logic [WIDTH:0] w_div_shl;
  logic [WIDTH:0] w_div_new;

  assign w_opnd_ext = {1'b0, i_opnd};
  assign w_mul_sum  = i_part[0] ? (i_acc + w_opnd_ext) : i_acc;

  // Divide: the partial remainder is a signed (WIDTH+1)-bit value; its sign
  // picks add or subtract and also yields the next quotient bit.
  assign w_div_shl = {i_acc[WIDTH-1:0], i_part[WIDTH-1]};
  assign w_div_new = i_acc[WIDTH] ? (w_div_shl + w_opnd_ext)
                                  : (w_div_shl - w_opnd_ext);

  always_comb begin
    if (i_op == OP_DIV) begin
      o_acc  = w_div_new;
      o_part = {i_part[WIDTH-2:0], ~w_div_new[WIDTH]};
    end else begin
      o_acc  = {1'b0, w_mul_sum[WIDTH:1]};
      o_part = {w_mul_sum[0], i_part[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/multdiv_seq_unit.sv
// multdiv_seq_unit: handshaked iterative signed multiply/divide with tagged
// result, exception flag, pipeline stall request and flush.
//
// state | meaning
// IDLE  | waiting for a request
// RUN   | iterating, one step per clock, WIDTH steps in total
// DONE  | result presented and held until result_ready
module multdiv_seq_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] result_tag,
  output logic             exception,
  output logic             stall_req
);

  localparam int                 CNT_W    = $clog2(WIDTH) + 1;
  localparam int                 MAG_W    = 2 * WIDTH + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [MAG_W-1:0]   MAG_LIM  = MAG_W'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op;
  logic             r_neg;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_opnd;
  logic [TAG_W-1:0] r_tag;
  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_res_tag;
  logic             r_exc;

  logic             w_start_ready;
  logic             w_accept;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_acc_nx;
  logic [WIDTH-1:0] w_part_nx;
  logic [MAG_W-1:0] w_mag;
  logic             w_ovf;
  logic [WIDTH-1:0] w_fix;

  assign w_start_ready = !flush && ((r_state == IDLE) ||
                                    (r_state == DONE && result_ready));
  assign w_accept      = start_valid && w_start_ready;
  assign w_b_zero      = (operand_b == '0);
  assign w_abs_a       = operand_a[WIDTH-1] ? (~operand_a + ONE_W) : operand_a;
  assign w_abs_b       = operand_b[WIDTH-1] ? (~operand_b + ONE_W) : operand_b;

  multdiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .i_acc  (r_acc),
    .i_part (r_part),
    .i_opnd (r_opnd),
    .i_op   (r_op),
    .o_acc  (w_acc_nx),
    .o_part (w_part_nx)
  );

  // Final magnitude of the last step; the signed range is asymmetric, so a
  // negative result may reach 2^(WIDTH-1) while a positive one may not.
  assign w_mag = (r_op == OP_DIV) ? {{(WIDTH+1){1'b0}}, w_part_nx}
                                  : {w_acc_nx, w_part_nx};
  assign w_ovf = r_neg ? (w_mag > MAG_LIM) : (w_mag >= MAG_LIM);
  assign w_fix = r_neg ? (~w_mag[WIDTH-1:0] + ONE_W) : w_mag[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_op      <= OP_MULT;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_part    <= '0;
      r_opnd    <= '0;
      r_tag     <= '0;
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_res_tag <= '0;
      r_exc     <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_acc  <= w_acc_nx;
          r_part <= w_part_nx;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state   <= DONE;
            r_valid   <= 1'b1;
            r_result  <= w_fix;
            r_res_tag <= r_tag;
            r_exc     <= w_ovf;
          end
        end
        IDLE, DONE: begin
          if (w_accept) begin
            r_op  <= op;
            r_neg <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            r_tag <= tag_in;
            r_cnt <= '0;
            r_acc <= '0;
            if (op == OP_DIV) begin
              r_part <= w_abs_a;
              r_opnd <= w_abs_b;
            end else begin
              r_part <= w_abs_b;
              r_opnd <= w_abs_a;
            end
            if (op == OP_DIV && w_b_zero) begin
              r_state   <= DONE;
              r_valid   <= 1'b1;
              r_result  <= '0;
              r_res_tag <= tag_in;
              r_exc     <= 1'b1;
            end else begin
              r_state <= RUN;
              r_valid <= 1'b0;
            end
          end else if (r_state == DONE && result_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready  = w_start_ready;
  assign result_valid = r_valid;
  assign result       = r_result;
  assign result_tag   = r_res_tag;
  assign exception    = r_exc;
  assign stall_req    = (r_state == RUN) ||
                        (r_state == DONE && !result_ready) ||
                        (r_state == IDLE && start_valid && !flush);

endmodule

// File: tb/tb_multdiv_seq_unit.sv
// tb_multdiv_seq_unit: directed vectors for the 32-bit and 8-bit
// multiply/divide unit with hand-computed expected results.
module tb_multdiv_seq_unit;
  import multdiv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        sv, fl, rr, opx;
  logic [31:0] a, b;
  logic [4:0]  tg;
  logic        srdy, rv, exc, stl;
  logic [31:0] res;
  logic [4:0]  rtag;

  logic        e_sv, e_fl, e_rr, e_op;
  logic [7:0]  e_a, e_b;
  logic [4:0]  e_tg;
  logic        e_srdy, e_rv, e_exc, e_stl;
  logic [7:0]  e_res;
  logic [4:0]  e_rtag;

  int n_vec = 0;
  int n_err = 0;

  multdiv_seq_unit #(.WIDTH(32), .TAG_W(5)) u_dut32 (
    .clock(clk), .reset(rst), .start_valid(sv), .start_ready(srdy),
    .op(opx), .operand_a(a), .operand_b(b), .tag_in(tg), .flush(fl),
    .result_valid(rv), .result_ready(rr), .result(res), .result_tag(rtag),
    .exception(exc), .stall_req(stl)
  );

  multdiv_seq_unit #(.WIDTH(8), .TAG_W(5)) u_dut8 (
    .clock(clk), .reset(rst), .start_valid(e_sv), .start_ready(e_srdy),
    .op(e_op), .operand_a(e_a), .operand_b(e_b), .tag_in(e_tg), .flush(e_fl),
    .result_valid(e_rv), .result_ready(e_rr), .result(e_res), .result_tag(e_rtag),
    .exception(e_exc), .stall_req(e_stl)
  );

  task automatic drive32(input logic o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] t);
    opx = o; a = x; b = y; tg = t; sv = 1'b1;
  endtask

  task automatic wait_valid32(output int lat, output int sc);
    lat = 0; sc = 0;
    while (rv !== 1'b1 && lat < 100) begin
      if (stl === 1'b1) sc++;
      @(negedge clk); lat++;
    end
  endtask

  task automatic wait_valid8(output int lat, output int sc);
    lat = 0; sc = 0;
    while (e_rv !== 1'b1 && lat < 100) begin
      if (e_stl === 1'b1) sc++;
      @(negedge clk); lat++;
    end
  endtask

  task automatic test_reset();
    sv = 0; fl = 1; rr = 0; opx = 0; a = 0; b = 0; tg = 0;
    e_sv = 0; e_fl = 1; e_rr = 0; e_op = 0; e_a = 0; e_b = 0; e_tg = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0; fl = 0; e_fl = 0;
    #1;
    n_vec++;
    if ({rv, res, rtag, exc} !== {1'b0, 32'h0, 5'h0, 1'b0}) begin
      n_err++; $display("FAIL reset32_out: got v=%b r=%h t=%0d e=%b want 0", rv, res, rtag, exc);
    end
    n_vec++;
    if ({srdy, stl} !== 2'b10) begin
      n_err++; $display("FAIL reset32_hs: got rdy=%b stall=%b want rdy=1 stall=0", srdy, stl);
    end
    n_vec++;
    if ({e_rv, e_res, e_rtag, e_exc, e_srdy} !== {1'b0, 8'h0, 5'h0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL reset8: got v=%b r=%h t=%0d e=%b rdy=%b", e_rv, e_res, e_rtag, e_exc, e_srdy);
    end
  endtask

  task automatic test_op32(input string nm, input logic o, input logic [31:0] x,
                           input logic [31:0] y, input logic [4:0] t,
                           input logic [31:0] er, input logic ee, input int el);
    int lat, sc;
    @(negedge clk);
    rr = 1; drive32(o, x, y, t);
    #1;
    n_vec++;
    if (srdy !== 1'b1) begin n_err++; $display("FAIL %s ready: got %b want 1", nm, srdy); end
    @(negedge clk); sv = 0;
    wait_valid32(lat, sc);
    n_vec++;
    if (lat != el) begin n_err++; $display("FAIL %s latency: got %0d want %0d", nm, lat, el); end
    n_vec++;
    if (sc != el) begin n_err++; $display("FAIL %s stall_cycles: got %0d want %0d", nm, sc, el); end
    n_vec++;
    if (res !== er) begin n_err++; $display("FAIL %s result: got %h want %h", nm, res, er); end
    n_vec++;
    if (rtag !== t) begin n_err++; $display("FAIL %s tag: got %0d want %0d", nm, rtag, t); end
    n_vec++;
    if (exc !== ee) begin n_err++; $display("FAIL %s exception: got %b want %b", nm, exc, ee); end
    n_vec++;
    if (stl !== 1'b0) begin n_err++; $display("FAIL %s done_stall: got %b want 0", nm, stl); end
    @(negedge clk);
    n_vec++;
    if (rv !== 1'b0) begin n_err++; $display("FAIL %s consumed: got valid=%b want 0", nm, rv); end
  endtask

  task automatic test_op8(input string nm, input logic o, input logic [7:0] x,
                          input logic [7:0] y, input logic [4:0] t,
                          input logic [7:0] er, input logic ee, input int el);
    int lat, sc;
    @(negedge clk);
    e_rr = 1; e_op = o; e_a = x; e_b = y; e_tg = t; e_sv = 1;
    @(negedge clk); e_sv = 0;
    wait_valid8(lat, sc);
    n_vec++;
    if (lat != el) begin n_err++; $display("FAIL %s latency: got %0d want %0d", nm, lat, el); end
    n_vec++;
    if ({e_res, e_rtag, e_exc} !== {er, t, ee}) begin
      n_err++; $display("FAIL %s out: got r=%h t=%0d e=%b want r=%h t=%0d e=%b", nm, e_res, e_rtag, e_exc, er, t, ee);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    bit seen;
    @(negedge clk);
    rr = 1; drive32(OP_MULT, 32'd6, 32'd7, 5'd11);
    @(negedge clk); sv = 0;
    repeat (9) @(negedge clk);
    fl = 1; #1;
    n_vec++;
    if ({srdy, stl} !== 2'b01) begin n_err++; $display("FAIL flush_run_hs: got rdy=%b stall=%b want 0 1", srdy, stl); end
    @(negedge clk); fl = 0; #1;
    n_vec++;
    if ({rv, srdy, stl} !== 3'b010) begin
      n_err++; $display("FAIL flush_idle: got v=%b rdy=%b stall=%b want 0 1 0", rv, srdy, stl);
    end
    seen = 0;
    repeat (40) begin @(negedge clk); if (rv === 1'b1) seen = 1; end
    n_vec++;
    if (seen) begin n_err++; $display("FAIL flush_discard: got valid seen=1 want 0"); end
    // flush and start_valid on the same edge must not accept
    drive32(OP_MULT, 32'd2, 32'd3, 5'd12); fl = 1; #1;
    n_vec++;
    if ({srdy, stl} !== 2'b00) begin n_err++; $display("FAIL flush_start_hs: got rdy=%b stall=%b want 0 0", srdy, stl); end
    @(negedge clk); sv = 0; fl = 0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (rv === 1'b1) seen = 1; end
    n_vec++;
    if (seen) begin n_err++; $display("FAIL flush_start_noaccept: got valid seen=1 want 0"); end
    test_op32("flush_after", OP_MULT, 32'd2, 32'd3, 5'd13, 32'd6, 1'b0, 32);
  endtask

  task automatic test_back_to_back();
    int lat, sc;
    @(negedge clk);
    rr = 0; drive32(OP_DIV, 32'd100, 32'd7, 5'd9);
    @(negedge clk); sv = 0;
    wait_valid32(lat, sc);
    n_vec++;
    if ({lat, res} !== {32'd32, 32'd14}) begin n_err++; $display("FAIL bp_first: got lat=%0d r=%0d want 32 14", lat, res); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_vec++;
      if ({rv, res, rtag, exc, stl, srdy} !== {1'b1, 32'd14, 5'd9, 1'b0, 1'b1, 1'b0}) begin
        n_err++; $display("FAIL bp_hold%0d: got v=%b r=%0d t=%0d e=%b stall=%b rdy=%b want 1 14 9 0 1 0",
                          i, rv, res, rtag, exc, stl, srdy);
      end
    end
    rr = 1; drive32(OP_MULT, 32'hFFFF_FFFC, 32'd5, 5'd10); #1;
    n_vec++;
    if ({srdy, stl} !== 2'b10) begin n_err++; $display("FAIL b2b_hs: got rdy=%b stall=%b want 1 0", srdy, stl); end
    @(negedge clk); sv = 0; rr = 0; #1;
    n_vec++;
    if ({rv, stl} !== 2'b01) begin n_err++; $display("FAIL b2b_run: got v=%b stall=%b want 0 1", rv, stl); end
    wait_valid32(lat, sc);
    n_vec++;
    if ({lat, res, rtag} !== {32'd32, 32'hFFFF_FFEC, 5'd10}) begin
      n_err++; $display("FAIL b2b_second: got lat=%0d r=%h t=%0d want 32 ffffffec 10", lat, res, rtag);
    end
    // flush together with result_ready in DONE just consumes the result
    fl = 1; rr = 1;
    @(negedge clk); fl = 0; rr = 0; #1;
    n_vec++;
    if ({rv, srdy, stl} !== 3'b010) begin
      n_err++; $display("FAIL flush_done: got v=%b rdy=%b stall=%b want 0 1 0", rv, srdy, stl);
    end
  endtask

  task automatic test_reset_mid();
    int lat, sc;
    @(negedge clk);
    rr = 0; drive32(OP_MULT, 32'd6, 32'd7, 5'd14);
    @(negedge clk); sv = 0;
    wait_valid32(lat, sc);
    n_vec++;
    if ({rv, res, rtag} !== {1'b1, 32'd42, 5'd14}) begin
      n_err++; $display("FAIL rmid_done: got v=%b r=%0d t=%0d want 1 42 14", rv, res, rtag);
    end
    rst = 1; fl = 1;
    @(negedge clk); rst = 0; fl = 0; #1;
    n_vec++;
    if ({rv, res, rtag, exc, srdy} !== {1'b0, 32'h0, 5'h0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL rmid_clear: got v=%b r=%h t=%0d e=%b rdy=%b want 0 0 0 0 1", rv, res, rtag, exc, srdy);
    end
  endtask

  initial begin
    test_reset();
    test_op32("mul_6x7",      OP_MULT, 32'd6,         32'd7,         5'd3, 32'd42,        1'b0, 32);
    test_op32("div_m7_2",     OP_DIV,  32'hFFFF_FFF9, 32'd2,         5'd4, 32'hFFFF_FFFD, 1'b0, 32);
    test_op32("div_min_m1",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h8000_0000, 1'b1, 32);
    test_op32("div_5_0",      OP_DIV,  32'd5,         32'd0,         5'd6, 32'd0,         1'b1, 0);
    test_op32("mul_max_2",    OP_MULT, 32'h7FFF_FFFF, 32'd2,         5'd7, 32'hFFFF_FFFE, 1'b1, 32);
    test_op32("mul_m3_m3",    OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 5'd8, 32'd9,         1'b0, 32);
    test_op32("div_7_m2",     OP_DIV,  32'd7,         32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, 1'b0, 32);
    test_op32("mul_min_1",    OP_MULT, 32'h8000_0000, 32'd1,         5'd16, 32'h8000_0000, 1'b0, 32);
    test_op32("mul_2p16_sq",  OP_MULT, 32'h0001_0000, 32'h0001_0000, 5'd17, 32'd0,         1'b1, 32);
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_op8("w8_mul_7f_2",   OP_MULT, 8'h7F, 8'h02, 5'd20, 8'hFE, 1'b1, 8);
    test_op8("w8_mul_m16_8",  OP_MULT, 8'hF0, 8'h08, 5'd21, 8'h80, 1'b0, 8);
    test_op8("w8_mul_16_8",   OP_MULT, 8'h10, 8'h08, 5'd22, 8'h80, 1'b1, 8);
    test_op8("w8_mul_m10_12", OP_MULT, 8'hF6, 8'h0C, 5'd23, 8'h88, 1'b0, 8);
    test_op8("w8_div_min_m1", OP_DIV,  8'h80, 8'hFF, 5'd24, 8'h80, 1'b1, 8);
    test_op8("w8_div_m7_2",   OP_DIV,  8'hF9, 8'h02, 5'd25, 8'hFD, 1'b0, 8);
    test_op8("w8_div_5_0",    OP_DIV,  8'h05, 8'h00, 5'd26, 8'h00, 1'b1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
